bicubic_block_transpose: RTL and testbench

- Downstream of the bicubic 4x upsample core; consumes its response stream: four beats per input window, each beat carrying four 8-bit output pixels.
- Each beat k (k=0..3) is column k of a 4x4 output block: lane j is row j.
- Collects a full 4x4 block into a ping-pong buffer and re-emits it row-major, one 4-pixel row per beat, for the line writer.
- Sustains one beat per cycle in and out.

---
 rtl/bicubic_block_transpose.sv | 118 +++++++++++
 tb/tb_bicubic_block_transpose.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bicubic_block_transpose.sv
// bicubic_block_transpose
// Collects 4x4 pixel blocks that arrive column by column from the bicubic
// upsample core and re-emits each block row by row for the line writer.
// Two banks are used as a ping-pong pair so one block can fill while the
// other drains, sustaining one beat per cycle on both sides.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   bcci_rsp_valid / bf_rsp_ready input column handshake
//   bcci_rsp_data1..4             rows 0..3 of the current column
//   out_valid / out_ready         output row handshake
//   out_data                      row pixels, col0 in the low byte
//   out_row                       row index within the block
//   out_last                      high on the final row of a block
module bicubic_block_transpose #(
  parameter int unsigned CHANNEL_WIDTH = 8,
  parameter int unsigned BLK           = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         bcci_rsp_valid,
  output logic                         bf_rsp_ready,
  input  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data1,
  input  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data2,
  input  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data3,
  input  logic [CHANNEL_WIDTH-1:0]     bcci_rsp_data4,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BLK*CHANNEL_WIDTH-1:0] out_data,
  output logic [1:0]                   out_row,
  output logic                         out_last
);

  localparam int unsigned CW    = CHANNEL_WIDTH;
  localparam int unsigned NBANK = 2;

  // Pixel storage: bank[b][row][col]; deliberately not reset.
  logic [CW-1:0] bank_q [NBANK][BLK][BLK];
  logic [CW-1:0] bank_d [NBANK][BLK][BLK];

  logic [NBANK-1:0] full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic [1:0]       wr_col_q, wr_col_d;
  logic             rd_bank_q, rd_bank_d;
  logic [1:0]       rd_row_q, rd_row_d;

  logic in_hsk;
  logic out_hsk;

  // Handshake flags are pure functions of registered state.
  assign bf_rsp_ready = ~full_q[wr_bank_q];
  assign out_valid    = full_q[rd_bank_q];
  assign in_hsk       = bcci_rsp_valid & bf_rsp_ready;
  assign out_hsk      = out_valid & out_ready;

  assign out_data = {bank_q[rd_bank_q][rd_row_q][3],
                     bank_q[rd_bank_q][rd_row_q][2],
                     bank_q[rd_bank_q][rd_row_q][1],
                     bank_q[rd_bank_q][rd_row_q][0]};
  assign out_row  = rd_row_q;
  assign out_last = (rd_row_q == 2'd3);

  // Column write into the current fill bank.
  always_comb begin
    bank_d = bank_q;
    if (in_hsk) begin
      bank_d[wr_bank_q][0][wr_col_q] = bcci_rsp_data1;
      bank_d[wr_bank_q][1][wr_col_q] = bcci_rsp_data2;
      bank_d[wr_bank_q][2][wr_col_q] = bcci_rsp_data3;
      bank_d[wr_bank_q][3][wr_col_q] = bcci_rsp_data4;
    end
  end

  // Fill/drain pointers and bank full flags. A write only targets a non-full
  // bank and a read only a full one, so set and clear never hit the same bank.
  always_comb begin
    full_d    = full_q;
    wr_bank_d = wr_bank_q;
    wr_col_d  = wr_col_q;
    rd_bank_d = rd_bank_q;
    rd_row_d  = rd_row_q;
    if (in_hsk) begin
      wr_col_d = wr_col_q + 2'd1;
      if (wr_col_q == 2'd3) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
      end
    end
    if (out_hsk) begin
      rd_row_d = rd_row_q + 2'd1;
      if (rd_row_q == 2'd3) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q    <= '0;
      wr_bank_q <= 1'b0;
      wr_col_q  <= 2'd0;
      rd_bank_q <= 1'b0;
      rd_row_q  <= 2'd0;
    end else begin
      full_q    <= full_d;
      wr_bank_q <= wr_bank_d;
      wr_col_q  <= wr_col_d;
      rd_bank_q <= rd_bank_d;
      rd_row_q  <= rd_row_d;
    end
  end

  always_ff @(posedge clk) begin
    bank_q <= bank_d;
  end

endmodule

// File: tb/tb_bicubic_block_transpose.sv
// Self-checking bench for bicubic_block_transpose: a reference transpose model
// fills a scoreboard on accepted input columns, and a monitor pops and compares
// on every output handshake while also checking hold-stability under stall.
module tb_bicubic_block_transpose;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  row;
    logic        last;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        bcci_rsp_valid;
  logic        bf_rsp_ready;
  logic [7:0]  d1, d2, d3, d4;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [1:0]  out_row;
  logic        out_last;

  bicubic_block_transpose #(.CHANNEL_WIDTH(8), .BLK(4)) dut (
    .clk            (clk),
    .rst            (rst),
    .bcci_rsp_valid (bcci_rsp_valid),
    .bf_rsp_ready   (bf_rsp_ready),
    .bcci_rsp_data1 (d1),
    .bcci_rsp_data2 (d2),
    .bcci_rsp_data3 (d3),
    .bcci_rsp_data4 (d4),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_row        (out_row),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t sb[$];

  int   in_cnt    = 0;
  int   out_cnt   = 0;
  int   last_cnt  = 0;
  int   run_len   = 0;
  int   max_run   = 0;
  int   stall_cnt = 0;
  logic ready_force = 1'b1;
  logic rnd_mode    = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Ready driver: forced level or ~50% random.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rnd_mode ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Reference model: gather accepted columns, push transposed rows.
  initial begin
    logic [7:0] mcol [4][4];
    int mc;
    exp_t e;
    mc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mc = 0;
      end else if (bcci_rsp_valid && bf_rsp_ready) begin
        in_cnt++;
        mcol[mc][0] = d1;
        mcol[mc][1] = d2;
        mcol[mc][2] = d3;
        mcol[mc][3] = d4;
        mc++;
        if (mc == 4) begin
          mc = 0;
          for (int r = 0; r < 4; r++) begin
            e.data = {mcol[3][r], mcol[2][r], mcol[1][r], mcol[0][r]};
            e.row  = 2'(r);
            e.last = (r == 3);
            sb.push_back(e);
          end
        end
      end
    end
  end

  // Output monitor: scoreboard compare and stall-stability.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic [1:0]  prev_row;
    logic        prev_last;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_row   = '0;
    prev_last  = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
        run_len    = 0;
      end else begin
        if (prev_stall) begin
          check_eq("hold_valid", 32'(out_valid), 32'd1);
          check_eq("hold_data", out_data, prev_data);
          check_eq("hold_row", 32'(out_row), 32'(prev_row));
          check_eq("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (out_valid && out_ready) begin
          out_cnt++;
          if (out_last) last_cnt++;
          run_len++;
          if (run_len > max_run) max_run = run_len;
          if (sb.size() == 0) begin
            check_eq("unexpected_row", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq("row_data", out_data, e.data);
            check_eq("row_idx", 32'(out_row), 32'(e.row));
            check_eq("row_last", 32'(out_last), 32'(e.last));
          end
        end else begin
          run_len = 0;
        end
        prev_stall = out_valid && !out_ready;
        prev_data  = out_data;
        prev_row   = out_row;
        prev_last  = out_last;
      end
    end
  end

  // Call just after a rising edge; returns just after the accepting edge.
  task automatic drive_beat(input logic [31:0] d);
    int n;
    bcci_rsp_valid = 1'b1;
    {d4, d3, d2, d1} = d;
    n = 0;
    forever begin
      @(negedge clk);
      if (bf_rsp_ready) break;
      stall_cnt++;
      n++;
      if (n > 1000) begin
        check_eq("in_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    bcci_rsp_valid = 1'b0;
  endtask

  // Column c lane j of block b: distinct, recognisable pattern.
  function automatic logic [31:0] pat(input int b, input int c);
    logic [7:0] l [4];
    for (int j = 0; j < 4; j++) l[j] = 8'(16 * j + c + 1 + 64 * b);
    return {l[3], l[2], l[1], l[0]};
  endfunction

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 5000) begin
        check_eq("drain_timeout", 32'(sb.size()), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int base;
    rst            = 1'b1;
    bcci_rsp_valid = 1'b0;
    {d4, d3, d2, d1} = '0;

    // Reset values while held and after release
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_held_valid", 32'(out_valid), 32'd0);
    check_eq("rst_held_ready", 32'(bf_rsp_ready), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(out_valid), 32'd0);
    check_eq("rst_ready", 32'(bf_rsp_ready), 32'd1);
    check_eq("rst_row", 32'(out_row), 32'd0);
    check_eq("rst_last", 32'(out_last), 32'd0);
    @(posedge clk);
    #1;

    // Single block with literal expected row 0 and latency
    for (int c = 0; c < 3; c++) drive_beat(pat(0, c));
    @(negedge clk);
    check_eq("pre_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    drive_beat(pat(0, 3));
    @(negedge clk);
    check_eq("lat_valid", 32'(out_valid), 32'd1);
    check_eq("lat_row", 32'(out_row), 32'd0);
    check_eq("lat_data", out_data, 32'h04030201);
    @(negedge clk);
    check_eq("row1_data", out_data, 32'h14131211);
    @(posedge clk);
    #1;
    wait_drain();

    // Streaming: 3 blocks gap-free
    base = stall_cnt;
    max_run = 0;
    for (int b = 0; b < 3; b++)
      for (int c = 0; c < 4; c++) drive_beat(pat(b + 1, c));
    wait_drain();
    check_eq("stream_stalls", 32'(stall_cnt - base), 32'd0);
    check_eq("stream_run", 32'(max_run), 32'd12);

    // Backpressure: only 8 beats fit, beat 9 held
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    base = in_cnt;
    fork
      begin
        for (int b = 0; b < 3; b++)
          for (int c = 0; c < 4; c++) drive_beat(pat(b + 2, c) ^ 32'h80808080);
      end
      begin
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_eq("bp_accepted", 32'(in_cnt - base), 32'd8);
        check_eq("bp_ready", 32'(bf_rsp_ready), 32'd0);
        check_eq("bp_held", 32'(bcci_rsp_valid), 32'd1);
        ready_force = 1'b1;
      end
    join
    wait_drain();
    check_eq("bp_total", 32'(in_cnt - base), 32'd12);

    // Random valid/ready over 100 blocks
    base = last_cnt;
    rnd_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk);
        #1;
      end
      drive_beat($urandom());
    end
    rnd_mode = 1'b0;
    wait_drain();
    check_eq("rand_last_cnt", 32'(last_cnt - base), 32'd100);

    // Reset with one full bank mid-read and a partial block
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 4; c++) drive_beat(pat(5, c));
    for (int c = 0; c < 2; c++) drive_beat(pat(6, c));
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    ready_force = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("mid_rst_valid", 32'(out_valid), 32'd0);
    check_eq("mid_rst_ready", 32'(bf_rsp_ready), 32'd1);
    check_eq("mid_rst_row", 32'(out_row), 32'd0);
    @(posedge clk);
    #1;
    ready_force = 1'b1;
    base = out_cnt;
    for (int c = 0; c < 4; c++) drive_beat(pat(7, c));
    wait_drain();
    check_eq("post_rst_rows", 32'(out_cnt - base), 32'd4);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
